// File: rtl/c7bifu_fetch_buf.sv
// Instruction fetch queue: aligns fetch beats to the expected address and presents one instruction per cycle.
// Latency: first word of an accepted beat reaches inst one cycle later (same cycle with C7BIFU_FETCH_BUF_BYPASS_EN).
// Backpressure: iq_full stalls beats (ignored, not dropped); inst_rdy low holds the head entry.
module c7bifu_fetch_buf #(
  parameter int DEPTH       = 8,
  parameter int FETCH_WORDS = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               data_addr,
  input  logic [32*FETCH_WORDS-1:0] data,
  input  logic                      data_vld,
  input  logic                      flush,
  input  logic [31:0]               start_addr,
  input  logic                      inst_rdy,
  output logic                      iq_full,
  output logic [$clog2(DEPTH):0]    iq_count,
  output logic                      inst_vld,
  output logic [31:0]               inst_addr,
  output logic [31:0]               inst,
  output logic                      stale_drop
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(FETCH_WORDS);
  localparam int OW = $clog2(FETCH_WORDS * 4);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
  } ent_t;

  // Entry storage carries no reset; validity is tracked by the pointers and count.
  ent_t mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   exp_addr_q, exp_addr_d;
  logic [SW-1:0] skip_q, skip_d;
  logic          stale_q, stale_d;

  logic          beat_ok;
  logic          accept;
  logic          q_vld;
  logic          pop_q;
  logic          byp_pop;
  logic [SW:0]   first_k;
  logic [SW:0]   wcnt;
  ent_t          head;
  ent_t          out_ent;

  logic          wen  [FETCH_WORDS];
  logic [PW-1:0] widx [FETCH_WORDS];
  ent_t          wdat [FETCH_WORDS];

  // Redirect targets are word aligned, so the byte offset bits carry no information.
  logic unused_start_lsb;
  assign unused_start_lsb = ^start_addr[1:0];

  assign head     = mem_q[rd_ptr_q];
  assign iq_count = count_q;
  assign iq_full  = (CW'(DEPTH) - count_q) < CW'(FETCH_WORDS);

  // A beat is only examined when there is room for a whole beat and no redirect is in progress.
  assign beat_ok = data_vld && !flush && !reset && !iq_full;
  assign accept  = beat_ok && (data_addr == exp_addr_q);
  assign stale_d = beat_ok && (data_addr != exp_addr_q);

  assign q_vld = (count_q != '0) && !flush;
  assign pop_q = q_vld && inst_rdy;

`ifdef C7BIFU_FETCH_BUF_BYPASS_EN
  logic byp;
  ent_t byp_ent;

  assign byp          = accept && (count_q == '0);
  assign byp_pop      = byp && inst_rdy;
  assign byp_ent.inst = data[{skip_q, 5'b00000} +: 32];
  assign byp_ent.addr = data_addr + {{(30-SW){1'b0}}, skip_q, 2'b00};
  assign inst_vld     = q_vld || byp;

  // Head of queue wins; an empty queue forwards the first live word of the accepted beat.
  always_comb begin
    out_ent = '0;
    if (q_vld) begin
      out_ent = head;
    end else if (byp) begin
      out_ent = byp_ent;
    end
  end
`else
  assign byp_pop  = 1'b0;
  assign inst_vld = q_vld;

  // Output is purely registered state: head entry when valid, zero otherwise.
  always_comb begin
    out_ent = '0;
    if (q_vld) begin
      out_ent = head;
    end
  end
`endif

  assign inst_addr  = out_ent.addr;
  assign inst       = out_ent.inst;
  assign stale_drop = stale_q;

  // Map beat words skip..FETCH_WORDS-1 onto consecutive entries, skipping a word consumed by bypass.
  always_comb begin
    first_k = {1'b0, skip_q} + {{SW{1'b0}}, byp_pop};
    wcnt    = accept ? ((SW+1)'(FETCH_WORDS) - first_k) : '0;
    for (int k = 0; k < FETCH_WORDS; k++) begin
      wen[k]       = accept && ((SW+1)'(k) >= first_k);
      widx[k]      = wr_ptr_q + PW'((SW+1)'(k) - first_k);
      wdat[k].inst = data[32*k +: 32];
      wdat[k].addr = data_addr + 32'(4 * k);
    end
  end

  // Next-state for pointers, occupancy and the expected-address tracker; redirect overrides all.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    exp_addr_d = exp_addr_q;
    skip_d     = skip_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      exp_addr_d = {start_addr[31:OW], {OW{1'b0}}};
      skip_d     = start_addr[OW-1:2];
    end else begin
      if (accept) begin
        wr_ptr_d   = wr_ptr_q + PW'(wcnt);
        exp_addr_d = exp_addr_q + 32'(FETCH_WORDS * 4);
        skip_d     = '0;
      end
      if (pop_q) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(wcnt) - CW'(pop_q);
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      exp_addr_q <= '0;
      skip_q     <= '0;
      stale_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      exp_addr_q <= exp_addr_d;
      skip_q     <= skip_d;
      stale_q    <= stale_d;
    end
  end

  // Entry array write; up to FETCH_WORDS entries per cycle, wrapping at the array end.
  always_ff @(posedge clk) begin
    for (int k = 0; k < FETCH_WORDS; k++) begin
      if (wen[k]) begin
        mem_q[widx[k]] <= wdat[k];
      end
    end
  end

endmodule

// File: tb/tb_c7bifu_fetch_buf.sv
// Bench for the fetch queue: directed scenarios plus random beats/pops/redirects against a queue model.
// Latency: outputs sampled 1ns after the falling edge, model advanced once per cycle.
// Backpressure: random inst_rdy and a producer that occasionally sends stale addresses.
module tb_c7bifu_fetch_buf;

  localparam int DEPTH = 8;
  localparam int FW    = 2;
  localparam int OW    = 3;
`ifdef C7BIFU_FETCH_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_addr = '0;
  logic [63:0] data = '0;
  logic        data_vld = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] start_addr = '0;
  logic        inst_rdy = 1'b0;
  logic        iq_full;
  logic [3:0]  iq_count;
  logic        inst_vld;
  logic [31:0] inst_addr;
  logic [31:0] inst;
  logic        stale_drop;

  logic [31:0]  d4_data_addr = '0;
  logic [127:0] d4_data = '0;
  logic         d4_data_vld = 1'b0;
  logic         d4_flush = 1'b0;
  logic [31:0]  d4_start_addr = '0;
  logic         d4_inst_rdy = 1'b0;
  logic         d4_iq_full;
  logic [3:0]   d4_iq_count;
  logic         d4_inst_vld;
  logic [31:0]  d4_inst_addr;
  logic [31:0]  d4_inst;
  logic         d4_stale_drop;

  always #5 clk = ~clk;

  c7bifu_fetch_buf #(.DEPTH(DEPTH), .FETCH_WORDS(FW)) u_dut (
    .clk(clk), .reset(reset), .data_addr(data_addr), .data(data), .data_vld(data_vld),
    .flush(flush), .start_addr(start_addr), .inst_rdy(inst_rdy), .iq_full(iq_full),
    .iq_count(iq_count), .inst_vld(inst_vld), .inst_addr(inst_addr), .inst(inst),
    .stale_drop(stale_drop)
  );

  c7bifu_fetch_buf #(.DEPTH(8), .FETCH_WORDS(4)) u_dut4 (
    .clk(clk), .reset(reset), .data_addr(d4_data_addr), .data(d4_data), .data_vld(d4_data_vld),
    .flush(d4_flush), .start_addr(d4_start_addr), .inst_rdy(d4_inst_rdy), .iq_full(d4_iq_full),
    .iq_count(d4_iq_count), .inst_vld(d4_inst_vld), .inst_addr(d4_inst_addr), .inst(d4_inst),
    .stale_drop(d4_stale_drop)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference model: a queue of (address, instruction) plus expected beat address and skip.
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_exp = '0;
  int          m_skip = 0;
  bit          m_stale = 1'b0;

  task automatic step(input bit fl, input logic [31:0] sa, input bit vld,
                      input logic [31:0] a, input logic [63:0] d, input bit rdy);
    bit          full_e, acc_e, byp_e, vld_e;
    logic [31:0] ia_e, id_e;
    ent_t        e;
    @(negedge clk);
    flush = fl; start_addr = sa; data_vld = vld; data_addr = a; data = d; inst_rdy = rdy;
    #1;
    full_e = (DEPTH - mq.size()) < FW;
    acc_e  = vld && !fl && !full_e && (a == m_exp);
    byp_e  = BYP && acc_e && (mq.size() == 0);
    vld_e  = ((mq.size() != 0) && !fl) || byp_e;
    ia_e = '0; id_e = '0;
    if (vld_e && mq.size() != 0) begin
      ia_e = mq[0].a; id_e = mq[0].d;
    end else if (vld_e) begin
      ia_e = a + 32'(4 * m_skip); id_e = d[32*m_skip +: 32];
    end
    chk("inst_vld", 32'(inst_vld), 32'(vld_e));
    chk("inst_addr", inst_addr, ia_e);
    chk("inst", inst, id_e);
    chk("iq_count", 32'(iq_count), 32'(mq.size()));
    chk("iq_full", 32'(iq_full), 32'(full_e));
    chk("stale_drop", 32'(stale_drop), 32'(m_stale));
    if (fl) begin
      mq.delete();
      m_exp   = sa & ~32'(FW * 4 - 1);
      m_skip  = int'(sa[OW-1:2]);
      m_stale = 1'b0;
    end else begin
      m_stale = vld && !full_e && (a != m_exp);
      if (vld_e && rdy && !byp_e) void'(mq.pop_front());
      if (acc_e) begin
        for (int k = m_skip; k < FW; k++) begin
          if (!(byp_e && rdy && k == m_skip)) begin
            e.a = a + 32'(4 * k);
            e.d = d[32*k +: 32];
            mq.push_back(e);
          end
        end
        m_exp  = m_exp + 32'(FW * 4);
        m_skip = 0;
      end
    end
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 32'h0, 1'b0, 32'h0, 64'h0, rdy);
  endtask

  task automatic beat(input logic [31:0] a, input logic [63:0] d, input bit rdy);
    step(1'b0, 32'h0, 1'b1, a, d, rdy);
  endtask

  task automatic redirect(input logic [31:0] sa);
    step(1'b1, sa, 1'b0, 32'h0, 64'h0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    flush = 1'b0; data_vld = 1'b0; inst_rdy = 1'b0;
    d4_flush = 1'b0; d4_data_vld = 1'b0;
    #1;
    chk("rst_inst_vld", 32'(inst_vld), 32'h0);
    chk("rst_iq_count", 32'(iq_count), 32'h0);
    chk("rst_iq_full", 32'(iq_full), 32'h0);
    chk("rst_stale", 32'(stale_drop), 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_addr", inst_addr, 32'h0);
    mq.delete(); m_exp = '0; m_skip = 0; m_stale = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic step4(input bit fl, input logic [31:0] sa, input bit vld, input logic [31:0] a);
    @(negedge clk);
    d4_flush = fl; d4_start_addr = sa; d4_data_vld = vld; d4_data_addr = a;
    d4_data = {32'h43, 32'h42, 32'h41, 32'h40} + {4{a}};
    #1;
  endtask

  initial begin
    logic [31:0] nxt;
    int          prev_cnt;

    do_reset();

    // Redirect into the middle of a beat: only the upper word survives.
    redirect(32'h104);
    beat(32'h100, {32'h0000BBBB, 32'h0000AAAA}, 1'b0);
    idle(1'b0);
    chk("skip_count", 32'(iq_count), 32'd1);
    chk("skip_addr", inst_addr, 32'h104);
    chk("skip_inst", inst, 32'h0000BBBB);
    idle(1'b1);

    // Stale beat dropped with a pulse, then the right beat accepted.
    redirect(32'h200);
    beat(32'h208, {$urandom, $urandom}, 1'b0);
    beat(32'h200, {32'h2222, 32'h1111}, 1'b0);
    chk("stale_pulse", 32'(stale_drop), 32'h1);
    idle(1'b1);
    chk("stale_next_a", inst_addr, 32'h200);
    chk("stale_clear", 32'(stale_drop), 32'h0);
    idle(1'b1);
    chk("stale_next_b", inst_addr, 32'h204);
    idle(1'b0);

    // Fill to full, then a beat is ignored without a stale pulse.
    redirect(32'h0);
    for (int i = 0; i < 4; i++) beat(32'(8 * i), {$urandom, $urandom}, 1'b0);
    idle(1'b0);
    chk("full_count", 32'(iq_count), 32'd8);
    chk("full_flag", 32'(iq_full), 32'h1);
    beat(32'h20, {$urandom, $urandom}, 1'b0);
    idle(1'b0);
    chk("full_ignored", 32'(iq_count), 32'd8);
    chk("full_no_stale", 32'(stale_drop), 32'h0);
    idle(1'b1);
    idle(1'b1);
    beat(32'h20, {$urandom, $urandom}, 1'b0);
    idle(1'b0);
    chk("full_exp_held", 32'(iq_count), 32'd8);

    // Steady stream with a pop every cycle across the array wrap.
    redirect(32'h0);
    nxt = 32'h0;
    prev_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      beat(32'(8 * i), {$urandom, $urandom}, 1'b1);
      if (i >= 2) chk("stream_rise", 32'(int'(iq_count) - prev_cnt), 32'd1);
      prev_cnt = int'(iq_count);
      if (inst_vld) begin
        chk("stream_order", inst_addr, nxt);
        nxt = nxt + 32'd4;
      end
    end
    for (int i = 0; i < 8; i++) begin
      idle(1'b1);
      if (inst_vld) begin
        chk("stream_order", inst_addr, nxt);
        nxt = nxt + 32'd4;
      end
    end
    chk("stream_drained", nxt, 32'd48);

    // Reset in the middle of operation empties the queue at once.
    redirect(32'h4);
    beat(32'h0, {$urandom, $urandom}, 1'b0);
    beat(32'h8, {$urandom, $urandom}, 1'b0);
    beat(32'h10, {$urandom, $urandom}, 1'b0);
    idle(1'b0);
    chk("pre_rst_count", 32'(iq_count), 32'd5);
    do_reset();
    beat(32'h0, {32'h5, 32'h4}, 1'b0);
    idle(1'b0);
    chk("post_rst_count", 32'(iq_count), 32'd2);
    chk("post_rst_inst", inst, 32'h4);
    for (int i = 0; i < 2; i++) idle(1'b1);

`ifdef C7BIFU_FETCH_BUF_BYPASS_EN
    beat(32'h8, {32'h9, 32'h8}, 1'b1);
    chk("byp_same_cycle", 32'(inst_vld), 32'h1);
    chk("byp_inst", inst, 32'h8);
    idle(1'b0);
    chk("byp_count", 32'(iq_count), 32'd1);
    idle(1'b1);
`endif

    // Four-word beats: mid-beat redirect, stale repeat, then the next aligned beat.
    step4(1'b1, 32'h10C, 1'b0, 32'h0);
    step4(1'b0, 32'h0, 1'b1, 32'h100);
    step4(1'b0, 32'h0, 1'b0, 32'h0);
    chk("fw4_count", 32'(d4_iq_count), 32'd1);
    chk("fw4_addr", d4_inst_addr, 32'h10C);
    chk("fw4_inst", d4_inst, 32'h143);
    step4(1'b0, 32'h0, 1'b1, 32'h100);
    step4(1'b0, 32'h0, 1'b0, 32'h0);
    chk("fw4_stale", 32'(d4_stale_drop), 32'h1);
    chk("fw4_count_held", 32'(d4_iq_count), 32'd1);
    step4(1'b0, 32'h0, 1'b1, 32'h110);
    step4(1'b0, 32'h0, 1'b0, 32'h0);
    chk("fw4_accept", 32'(d4_iq_count), 32'd5);
    chk("fw4_full", 32'(d4_iq_full), 32'h1);

    // Random traffic: mostly in-order beats, some stale ones, redirects and resets.
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] a;
      if (i % 500 == 250) do_reset();
      a = ($urandom_range(0, 7) == 0) ? (m_exp ^ (32'($urandom_range(1, 3)) << 3)) : m_exp;
      step($urandom_range(0, 31) == 0, 32'h1000 + (32'($urandom_range(0, 63)) << 2),
           $urandom_range(0, 3) != 0, a, {$urandom, $urandom}, $urandom_range(0, 2) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/c7bifu_fetch_buf.md
C7BIFU_FETCH_BUF -- requirements
Module: c7bifu_fetch_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning queue depth in 32-bit instruction entries; power of 2, at least 2*FETCH_WORDS.
REQ-002 SHALL have parameter FETCH_WORDS, default 2, meaning instructions per fetch beat; legal values 2 or 4.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port data_addr, input, 32, byte address of the fetch beat; aligned to FETCH_WORDS*4.
REQ-006 SHALL have port data, input, 32*FETCH_WORDS, fetch beat with word k in bits [32k+31:32k].
REQ-007 SHALL have port data_vld, input, 1, fetch beat valid.
REQ-008 SHALL have port flush, input, 1, redirect request.
REQ-009 SHALL have port start_addr, input, 32, redirect target, word aligned, sampled when flush=1.
REQ-010 SHALL have port inst_rdy, input, 1, consumer accepts inst this cycle.
REQ-011 SHALL have port iq_full, output, 1, fewer than FETCH_WORDS free entries.
REQ-012 SHALL have port iq_count, output, clog2(DEPTH)+1, occupied entries.
REQ-013 SHALL have port inst_vld, output, 1, head entry valid.
REQ-014 SHALL have port inst_addr, output, 32, head instruction address.
REQ-015 SHALL have port inst, output, 32, head instruction.
REQ-016 SHALL have port stale_drop, output, 1, one-cycle pulse when a beat is discarded for address mismatch.

Function
REQ-017 SHALL track exp_addr (next expected beat address) and skip (word offset, log2(FETCH_WORDS) bits).
REQ-018 On flush: SHALL clear pointers and count, set exp_addr = start_addr with the low log2(FETCH_WORDS*4) bits zeroed, set skip = start_addr[log2(FETCH_WORDS*4)-1:2]; flush has priority, and a same-cycle beat or pop SHALL have no effect.
REQ-019 A beat SHALL be accepted when data_vld=1, flush=0, iq_full=0 and data_addr==exp_addr.
REQ-020 On acceptance, SHALL write words skip..FETCH_WORDS-1 to consecutive entries at addresses data_addr+4k, SHALL advance exp_addr by FETCH_WORDS*4, and SHALL clear skip to 0.
REQ-021 A beat with data_vld=1, flush=0, iq_full=0 and data_addr!=exp_addr SHALL be discarded with stale_drop=1 the next cycle; state SHALL be unchanged.
REQ-022 A beat arriving while iq_full=1 SHALL be ignored without stale_drop; the producer holds or refetches it.
REQ-023 inst_vld SHALL equal (iq_count!=0 and flush=0); inst and inst_addr SHALL be the head entry when inst_vld=1 and 0 otherwise.
REQ-024 A pop SHALL occur when inst_vld=1 and inst_rdy=1; inst_vld SHALL not depend on inst_rdy.
REQ-025 Same-cycle accept of n words and a pop SHALL update iq_count by n-1.
REQ-026 Pointers SHALL wrap modulo DEPTH; multi-word writes straddling the array end SHALL wrap to entry 0.
REQ-027 iq_full SHALL be combinational from iq_count: (DEPTH - iq_count) < FETCH_WORDS.
REQ-028 Without bypass, the first word of an accepted beat SHALL appear on inst one cycle after acceptance.

Reset
REQ-029 While reset=1, SHALL hold pointers, iq_count, skip and exp_addr at 0, and SHALL drive inst_vld, inst, inst_addr, stale_drop and iq_full to 0.
REQ-030 Reset mid-operation SHALL discard all entries immediately; after release, a beat at address 0 SHALL be accepted.
REQ-031 Entry storage SHALL not require reset.

Configuration
REQ-032 Macro C7BIFU_FETCH_BUF_BYPASS_EN: when defined and iq_count=0 with a beat being accepted, inst_vld SHALL be 1 in the same cycle with the first written word on inst and inst_addr.
REQ-033 With C7BIFU_FETCH_BUF_BYPASS_EN defined and inst_rdy=1 on that cycle, the bypassed word SHALL not be stored, and iq_count SHALL increase by n-1.
REQ-034 When C7BIFU_FETCH_BUF_BYPASS_EN is undefined, there SHALL be no combinational path from data or data_vld to inst_vld, inst or inst_addr.

Verification (DEPTH=8, FETCH_WORDS=2 unless stated)
REQ-035 flush with start_addr=0x104, then beat 0x100 data=0xBBBB_AAAA -> single entry, inst_addr=0x104, inst=0xBBBB, iq_count=1.
REQ-036 flush to 0x200, beats 0x208 then 0x200 -> first beat pulses stale_drop=1; second beat is accepted and yields 0x200 then 0x204.
REQ-037 inst_rdy=0 with four beats 0x0..0x18 -> iq_count=8, iq_full=1; fifth beat is ignored, exp_addr stays 0x20.
REQ-038 Steady state, one beat plus one pop per cycle across wrap -> iq_count rises by 1 per cycle, and addresses are output in strict order with no gap.
REQ-039 FETCH_WORDS=4, flush to 0x10C, beat 0x100 -> one entry, 0x10C; next beat accepted at 0x110 only.
REQ-040 Assert reset with iq_count=5 -> next cycle inst_vld=0 and iq_count=0; with bypass defined, empty-queue accept with inst_rdy=1 -> same-cycle inst_vld=1, iq_count=1 next cycle.
